// File: rtl/spiflash_reader_pkg.sv
// Shared types and constants for the SPI flash read engine.
// HOLD/GAP states exist only when SPIFLASH_READER_CONTINUE_EN is defined.
package spiflash_reader_pkg;

    localparam logic [7:0]  CMD_READ   = 8'h03;
    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 24;
    localparam int unsigned DATA_BITS  = 32;
    localparam int unsigned TOTAL_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

`ifdef SPIFLASH_READER_CONTINUE_EN
    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StData, StDone, StHold, StGap
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StData, StDone
    } state_e;
`endif

    // Bytes arrive first-byte-first in the MSBs; the bus wants little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spiflash_bitclk.sv
// SPI clock divider: flash_clk toggles every CLK_DIV cycles while enabled,
// with single-cycle strobes on the clk edge where flash_clk rises/falls.
module spiflash_bitclk #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic flash_clk,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt_q, cnt_d;
    logic       clk_q, clk_d;
    logic       tick;

    always_comb begin
        tick  = en && (cnt_q == 8'(CLK_DIV - 1));
        rise  = tick && !clk_q;
        fall  = tick && clk_q;
        cnt_d = 8'd0;
        clk_d = 1'b0;
        if (en) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
            clk_d = clk_q ^ tick;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign flash_clk = clk_q;

endmodule

// File: rtl/spiflash_reader.sv
// Single-bit SPI flash READ (0x03) engine: one little-endian word per valid/ready request.
// Define SPIFLASH_READER_CONTINUE_EN to keep CS low and stream sequential words.
module spiflash_reader
    import spiflash_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [23:0] addr,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    state_e      state_q, state_d;
    logic [21:0] addr_q, addr_d;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  bit_q, bit_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        csb_q, csb_d;
    logic        sck_en, rise, fall;
    logic        accept;
    logic        unused_addr_lsb;
`ifdef SPIFLASH_READER_CONTINUE_EN
    logic [21:0] next_q, next_d;
    logic        gap_q, gap_d;
`endif

    assign unused_addr_lsb = ^addr[1:0];

    spiflash_bitclk #(
        .CLK_DIV (CLK_DIV)
    ) u_bitclk (
        .clk       (clk),
        .rst       (rst),
        .en        (sck_en),
        .flash_clk (flash_clk),
        .rise      (rise),
        .fall      (fall)
    );

    // ready_q high means the bus is still completing the previous handshake.
    assign accept = valid && !ready_q;
    assign sck_en = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        csb_d   = csb_q;
`ifdef SPIFLASH_READER_CONTINUE_EN
        next_d  = next_q;
        gap_d   = gap_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = addr[23:2];
                    sr_d    = {CMD_READ, addr[23:2], 2'b00};
                    bit_d   = 6'd0;
                    csb_d   = 1'b0;
                    state_d = StCmd;
                end
            end
            StCmd, StAddr: begin
                if (fall) begin
                    sr_d  = {sr_q[30:0], 1'b0};
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'(CMD_BITS - 1)) state_d = StAddr;
                    if (bit_q == 6'(CMD_BITS + ADDR_BITS - 1)) state_d = StData;
                end
            end
            StData: begin
                if (rise) sr_d = {sr_q[30:0], flash_io1};
                if (fall) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'(TOTAL_BITS - 1)) state_d = StDone;
                end
            end
            StDone: begin
                ready_d = 1'b1;
                rdata_d = bswap32(sr_q);
`ifdef SPIFLASH_READER_CONTINUE_EN
                next_d  = addr_q + 22'd1;
                state_d = StHold;
`else
                csb_d   = 1'b1;
                state_d = StIdle;
`endif
            end
`ifdef SPIFLASH_READER_CONTINUE_EN
            StHold: begin
                if (accept) begin
                    addr_d = addr[23:2];
                    if (addr[23:2] == next_q) begin
                        // Flash is already positioned at the next word.
                        bit_d   = 6'(CMD_BITS + ADDR_BITS);
                        state_d = StData;
                    end else begin
                        csb_d   = 1'b1;
                        gap_d   = 1'b0;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q) begin
                    sr_d    = {CMD_READ, addr_q, 2'b00};
                    bit_d   = 6'd0;
                    csb_d   = 1'b0;
                    state_d = StCmd;
                end else begin
                    gap_d = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= 22'd0;
            sr_q    <= 32'd0;
            bit_q   <= 6'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            csb_q   <= 1'b1;
`ifdef SPIFLASH_READER_CONTINUE_EN
            next_q  <= 22'd0;
            gap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            csb_q   <= csb_d;
`ifdef SPIFLASH_READER_CONTINUE_EN
            next_q  <= next_d;
            gap_q   <= gap_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign flash_csb = csb_q;
    assign flash_io0 = ((state_q == StCmd) || (state_q == StAddr)) ? sr_q[31] : 1'b0;

endmodule

// File: tb/tb_spiflash_reader.sv
// Bench for spiflash_reader: two instances (CLK_DIV 1 and 3), each wired to a
// behavioural SPI flash; expectations come from a request-level latency/data model.
module tb_spiflash_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid [2];
    logic [23:0] addr  [2];
    logic        ready [2];
    logic [31:0] rdata [2];
    logic        csb   [2];
    logic        fclk  [2];
    logic        io0   [2];
    logic        io1   [2];

    int total = 0;
    int bad   = 0;

    // Flash/monitor state, all written only by the monitor process.
    int          fl_cnt    [2];
    logic [31:0] cap       [2];
    int          rdy_cnt   [2];
    int          hi_cnt    [2];
    int          rises     [2];
    int          csb_rises [2];
    int          run       [2];
    int          last_run  [2];
    logic        pcsb      [2];
    logic        pclk      [2];

    // Request-level model of the continuation window.
    bit          hold [2];
    logic [23:0] nxt  [2];

    always #5 clk = ~clk;

    spiflash_reader #(.CLK_DIV(1)) dut0 (
        .clk(clk), .rst(rst), .valid(valid[0]), .addr(addr[0]), .ready(ready[0]),
        .rdata(rdata[0]), .flash_csb(csb[0]), .flash_clk(fclk[0]), .flash_io0(io0[0]),
        .flash_io1(io1[0])
    );

    spiflash_reader #(.CLK_DIV(3)) dut1 (
        .clk(clk), .rst(rst), .valid(valid[1]), .addr(addr[1]), .ready(ready[1]),
        .rdata(rdata[1]), .flash_csb(csb[1]), .flash_clk(fclk[1]), .flash_io0(io0[1]),
        .flash_io1(io1[1])
    );

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        case (a)
            24'h100000: return 8'h13;
            24'h100001, 24'h100002, 24'h100003: return 8'h00;
            24'h000040: return 8'hEF;
            24'h000041: return 8'hBE;
            24'h000042: return 8'hAD;
            24'h000043: return 8'hDE;
            default: return a[7:0] ^ (a[15:8] * 8'd3) ^ (a[23:16] * 8'd7) ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [23:0] w;
        w = {a[23:2], 2'b00};
        return {mem_rd(w + 24'd3), mem_rd(w + 24'd2), mem_rd(w + 24'd1), mem_rd(w)};
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit full_path(input int i, input logic [23:0] a);
`ifdef SPIFLASH_READER_CONTINUE_EN
        if (hold[i] && a[23:2] == nxt[i][23:2]) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic int exp_lat(input int i, input logic [23:0] a);
        int d;
        d = div_of(i);
`ifdef SPIFLASH_READER_CONTINUE_EN
        if (hold[i] && a[23:2] == nxt[i][23:2]) return 2 + 64 * d;
        if (hold[i]) return 4 + 128 * d;
`endif
        return 2 + 128 * d;
    endfunction

    task automatic note_done(input int i, input logic [23:0] a);
        hold[i] = 1'b1;
        nxt[i]  = {a[23:2], 2'b00} + 24'd4;
    endtask

    // Behavioural flash + activity monitor, sampled away from the active edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ready[g]) rdy_cnt[g]++;
            if (fclk[g]) hi_cnt[g]++;
            if (csb[g]) begin
                run[g]++;
                if (!pcsb[g]) csb_rises[g]++;
                fl_cnt[g] = 0;
                io1[g]    = 1'b0;
            end else begin
                if (run[g] > 0) last_run[g] = run[g];
                run[g] = 0;
                if (fclk[g] && !pclk[g]) begin
                    rises[g]++;
                    if (fl_cnt[g] < 32) cap[g] = {cap[g][30:0], io0[g]};
                    fl_cnt[g]++;
                end else if (!fclk[g] && pclk[g] && fl_cnt[g] >= 32) begin
                    int          idx;
                    logic [23:0] ba;
                    logic [7:0]  b;
                    idx     = fl_cnt[g] - 32;
                    ba      = cap[g][23:0] + 24'(idx / 8);
                    b       = mem_rd(ba);
                    io1[g]  = b[7 - (idx % 8)];
                end
            end
            pcsb[g] = csb[g];
            pclk[g] = fclk[g];
        end
    end

    task automatic do_read(input int i, input logic [23:0] a, input int drop_at,
                           output int lat, output logic [31:0] data);
        logic r;
        logic [31:0] d;
        bit got;
        got  = 1'b0;
        lat  = -1;
        data = 32'd0;
        @(negedge clk);
        valid[i] = 1'b1;
        addr[i]  = a;
        @(posedge clk);
        #1 addr[i] = 24'($urandom);
        for (int k = 1; k <= 2000 && !got; k++) begin
            @(negedge clk);
            r = ready[i];
            d = rdata[i];
            if (k == drop_at) valid[i] = 1'b0;
            @(posedge clk);
            if (r) begin
                got  = 1'b1;
                lat  = k;
                data = d;
            end
        end
        #1 valid[i] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (csb[i] !== 1'b1 || fclk[i] !== 1'b0 || io0[i] !== 1'b0 ||
                ready[i] !== 1'b0 || rdata[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_outputs[%0d] got csb=%b clk=%b io0=%b rdy=%b rdata=%h want 1 0 0 0 0",
                         i, csb[i], fclk[i], io0[i], ready[i], rdata[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (csb[i] !== 1'b1 || fclk[i] !== 1'b0 || ready[i] !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_reset[%0d] got csb=%b clk=%b rdy=%b want 1 0 0",
                         i, csb[i], fclk[i], ready[i]);
            end
        end
    endtask

    task automatic test_basic;
        logic [23:0] al [2];
        al[0] = 24'h100000;
        al[1] = 24'h100003;
        for (int n = 0; n < 2; n++) begin
            int lat, el, r0;
            logic [31:0] d;
            el = exp_lat(0, al[n]);
            r0 = rdy_cnt[0];
            do_read(0, al[n], 0, lat, d);
            total++;
            if (lat !== el) begin
                bad++; $display("FAIL basic_latency a=%h got=%0d want=%0d", al[n], lat, el);
            end
            total++;
            if (d !== 32'h00000013) begin
                bad++; $display("FAIL basic_rdata a=%h got=%h want=00000013", al[n], d);
            end
            total++;
            if (cap[0] !== 32'h03100000) begin
                bad++; $display("FAIL basic_mosi a=%h got=%h want=03100000", al[n], cap[0]);
            end
            total++;
            if (rdy_cnt[0] - r0 !== 1) begin
                bad++; $display("FAIL basic_ready_pulses got=%0d want=1", rdy_cnt[0] - r0);
            end
            note_done(0, al[n]);
        end
    endtask

    task automatic test_clkdiv3;
        int lat, el, h0, s0;
        logic [31:0] d;
        el = exp_lat(1, 24'h000040);
        h0 = hi_cnt[1];
        s0 = rises[1];
        do_read(1, 24'h000040, 0, lat, d);
        total++;
        if (lat !== 386 || el !== 386) begin
            bad++; $display("FAIL div3_latency got=%0d want=386", lat);
        end
        total++;
        if (d !== 32'hDEADBEEF) begin
            bad++; $display("FAIL div3_rdata got=%h want=deadbeef", d);
        end
        total++;
        if (hi_cnt[1] - h0 !== 192 || rises[1] - s0 !== 64) begin
            bad++; $display("FAIL div3_sck got high=%0d rises=%0d want high=192 rises=64",
                            hi_cnt[1] - h0, rises[1] - s0);
        end
        total++;
        if (cap[1] !== 32'h03000040) begin
            bad++; $display("FAIL div3_mosi got=%h want=03000040", cap[1]);
        end
        note_done(1, 24'h000040);
    endtask

    task automatic test_drop;
        int lat, el, r0;
        logic [31:0] d;
        logic [23:0] a;
        a  = 24'($urandom);
        el = exp_lat(0, a);
        r0 = rdy_cnt[0];
        do_read(0, a, 10, lat, d);
        total++;
        if (lat !== el || d !== exp_word(a)) begin
            bad++; $display("FAIL drop_result got lat=%0d data=%h want lat=%0d data=%h",
                            lat, d, el, exp_word(a));
        end
        note_done(0, a);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (rdy_cnt[0] - r0 !== 1) begin
            bad++; $display("FAIL drop_ready_pulses got=%0d want=1", rdy_cnt[0] - r0);
        end
        total++;
`ifdef SPIFLASH_READER_CONTINUE_EN
        if (csb[0] !== 1'b0) begin
            bad++; $display("FAIL drop_idle_csb got=%b want=0", csb[0]);
        end
`else
        if (csb[0] !== 1'b1) begin
            bad++; $display("FAIL drop_idle_csb got=%b want=1", csb[0]);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, el1, el2, c0;
        logic [31:0] d1, d2;
        logic [23:0] a1, a2;
        a1  = 24'($urandom);
        a2  = a1 ^ 24'h800000;
        c0  = csb_rises[0];
        el1 = exp_lat(0, a1);
        do_read(0, a1, 0, lat1, d1);
        note_done(0, a1);
        el2 = exp_lat(0, a2);
        do_read(0, a2, 0, lat2, d2);
        note_done(0, a2);
        total++;
        if (lat1 !== el1 || d1 !== exp_word(a1)) begin
            bad++; $display("FAIL b2b_first got lat=%0d data=%h want lat=%0d data=%h",
                            lat1, d1, el1, exp_word(a1));
        end
        total++;
        if (lat2 !== el2 || d2 !== exp_word(a2)) begin
            bad++; $display("FAIL b2b_second got lat=%0d data=%h want lat=%0d data=%h",
                            lat2, d2, el2, exp_word(a2));
        end
`ifndef SPIFLASH_READER_CONTINUE_EN
        total++;
        if (csb_rises[0] - c0 !== 2) begin
            bad++; $display("FAIL b2b_csb_rises got=%0d want=2", csb_rises[0] - c0);
        end
`endif
    endtask

    task automatic test_wrap;
        logic [23:0] al [2];
        al[0] = 24'hFFFFFC;
        al[1] = 24'h000001;
        for (int n = 0; n < 2; n++) begin
            int lat, el;
            logic [31:0] d;
            el = exp_lat(0, al[n]);
            do_read(0, al[n], 0, lat, d);
            total++;
            if (lat !== el || d !== exp_word(al[n])) begin
                bad++; $display("FAIL wrap a=%h got lat=%0d data=%h want lat=%0d data=%h",
                                al[n], lat, d, el, exp_word(al[n]));
            end
            note_done(0, al[n]);
        end
    endtask

    task automatic test_random;
        logic [23:0] prev;
        prev = 24'h0;
        for (int n = 0; n < 10; n++) begin
            int i, lat, el, r0;
            bit full;
            logic [31:0] d;
            logic [23:0] a;
            i = (n % 5 == 4) ? 1 : 0;
            if (n > 0 && i == 0 && $urandom_range(0, 1) == 1)
                a = {prev[23:2], 2'b00} + 24'd4 + 24'($urandom_range(0, 3));
            else
                a = 24'($urandom);
            el   = exp_lat(i, a);
            full = full_path(i, a);
            r0   = rdy_cnt[i];
            do_read(i, a, 0, lat, d);
            total++;
            if (lat !== el || d !== exp_word(a) || rdy_cnt[i] - r0 !== 1) begin
                bad++; $display("FAIL rand[%0d] a=%h got lat=%0d data=%h pulses=%0d want lat=%0d data=%h pulses=1",
                                n, a, lat, d, rdy_cnt[i] - r0, el, exp_word(a));
            end
            if (full) begin
                total++;
                if (cap[i] !== {8'h03, a[23:2], 2'b00}) begin
                    bad++; $display("FAIL rand_mosi[%0d] got=%h want=%h", n, cap[i],
                                    {8'h03, a[23:2], 2'b00});
                end
            end
            note_done(i, a);
            if (i == 0) prev = a;
        end
    endtask

    task automatic test_mid_reset;
        int r0, lat;
        logic [31:0] d;
        r0 = rdy_cnt[0];
        @(negedge clk);
        valid[0] = 1'b1;
        addr[0]  = 24'h100000;
        @(posedge clk);
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (csb[0] !== 1'b1 || fclk[0] !== 1'b0 || ready[0] !== 1'b0 || rdata[0] !== 32'd0 ||
            io0[0] !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs got csb=%b clk=%b rdy=%b rdata=%h io0=%b want 1 0 0 0 0",
                            csb[0], fclk[0], ready[0], rdata[0], io0[0]);
        end
        valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        total++;
        if (rdy_cnt[0] - r0 !== 0) begin
            bad++; $display("FAIL midreset_no_ready got=%0d want=0", rdy_cnt[0] - r0);
        end
        do_read(0, 24'h100000, 0, lat, d);
        total++;
        if (lat !== 130 || d !== 32'h00000013) begin
            bad++; $display("FAIL midreset_recover got lat=%0d data=%h want lat=130 data=00000013",
                            lat, d);
        end
        note_done(0, 24'h100000);
    endtask

`ifdef SPIFLASH_READER_CONTINUE_EN
    task automatic test_continue;
        int lat, el, c0;
        logic [31:0] d;
        el = exp_lat(0, 24'h100000);
        do_read(0, 24'h100000, 0, lat, d);
        note_done(0, 24'h100000);
        total++;
        if (lat !== el || d !== 32'h00000013) begin
            bad++; $display("FAIL cont_first got lat=%0d data=%h want lat=%0d data=00000013",
                            lat, d, el);
        end
        c0 = csb_rises[0];
        do_read(0, 24'h100004, 0, lat, d);
        note_done(0, 24'h100004);
        total++;
        if (lat !== 66 || d !== exp_word(24'h100004)) begin
            bad++; $display("FAIL cont_seq got lat=%0d data=%h want lat=66 data=%h",
                            lat, d, exp_word(24'h100004));
        end
        total++;
        if (csb_rises[0] - c0 !== 0) begin
            bad++; $display("FAIL cont_csb_rises got=%0d want=0", csb_rises[0] - c0);
        end
        do_read(0, 24'h200000, 0, lat, d);
        note_done(0, 24'h200000);
        total++;
        if (lat !== 132 || d !== exp_word(24'h200000)) begin
            bad++; $display("FAIL cont_jump got lat=%0d data=%h want lat=132 data=%h",
                            lat, d, exp_word(24'h200000));
        end
        total++;
        if (last_run[0] !== 2 || cap[0] !== 32'h03200000) begin
            bad++; $display("FAIL cont_gap got gap=%0d mosi=%h want gap=2 mosi=03200000",
                            last_run[0], cap[0]);
        end
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; addr[i] = 24'd0; io1[i] = 1'b0;
            fl_cnt[i] = 0; cap[i] = 32'd0; rdy_cnt[i] = 0; hi_cnt[i] = 0; rises[i] = 0;
            csb_rises[i] = 0; run[i] = 0; last_run[i] = 0; pcsb[i] = 1'b1; pclk[i] = 1'b0;
            hold[i] = 1'b0; nxt[i] = 24'd0;
        end
        test_reset();
        test_basic();
        test_clkdiv3();
        test_drop();
        test_back_to_back();
        test_wrap();
        test_random();
        test_mid_reset();
`ifdef SPIFLASH_READER_CONTINUE_EN
        test_continue();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
